// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency, in-order fetch responses from a
// preloadable word array, with a taken-branch flush of responses in flight.
module imem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        proc2Imem_req,
    input  logic [31:0] proc2Imem_addr,
    input  logic        flush,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] Imem2proc_data,
    output logic        Imem2proc_valid,
    output logic        Imem2proc_err,
    output logic [2:0]  outstanding
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    localparam resp_t BUBBLE = '{valid: 1'b0, err: 1'b0, data: NOOP_INST};

    logic [31:0] mem [DEPTH_WORDS];
    resp_t       pipe [LATENCY];
    resp_t       fetch_resp;
    logic [2:0]  next_outstanding;
    logic        fetch_in_range;
    logic        load_in_range;
    logic        unused_addr_bits;

    assign fetch_in_range   = (proc2Imem_addr[31:AW+2] == '0);
    assign load_in_range    = (load_addr[31:AW+2] == '0);
    assign unused_addr_bits = &{1'b0, proc2Imem_addr[1:0], load_addr[1:0]};

    // NOTE: the storage array has no reset; preloaded contents survive rst.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    // The array write lands after this edge, so a same-cycle fetch of the
    // same word sees the old contents (read-before-write).
    always_comb begin
        // NOTE: default first so every path assigns fetch_resp and no latch is inferred.
        fetch_resp = BUBBLE;
        if (proc2Imem_req) begin
            fetch_resp.valid = 1'b1;
            if (fetch_in_range) begin
                fetch_resp.data = mem[proc2Imem_addr[AW+1:2]];
            end else begin
                fetch_resp.err = 1'b1;
            end
        end
    end

    // Stages that survive the next edge: the new request plus, unless
    // flushing, everything except the entry now leaving the output stage.
    always_comb begin
        next_outstanding = {2'b00, proc2Imem_req};
        if (!flush) begin
            for (int i = 0; i < LATENCY - 1; i++) begin
                next_outstanding = next_outstanding + {2'b00, pipe[i].valid};
            end
        end
    end

    // NOTE: non-blocking assignments so every stage shifts from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= BUBBLE;
            end
            outstanding <= '0;
        end else begin
            pipe[0] <= fetch_resp;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= flush ? BUBBLE : pipe[i-1];
            end
            outstanding <= next_outstanding;
        end
    end

    assign Imem2proc_data  = pipe[LATENCY-1].data;
    assign Imem2proc_valid = pipe[LATENCY-1].valid;
    assign Imem2proc_err   = pipe[LATENCY-1].err;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench: four responders (LATENCY 1..4) share one stimulus stream;
// each is compared every cycle against a queue-based response model.
module tb_imem_responder;
    localparam logic [31:0] NOOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] fetch_addr;
    logic        flush;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_lat
        localparam int L = g + 1;

        logic [31:0] data;
        logic        valid;
        logic        err;
        logic [2:0]  outs;

        imem_responder #(.DEPTH_WORDS(1024), .LATENCY(L)) dut (
            .clk             (clk),
            .rst             (rst),
            .proc2Imem_req   (req),
            .proc2Imem_addr  (fetch_addr),
            .flush           (flush),
            .load_en         (load_en),
            .load_addr       (load_addr),
            .load_data       (load_data),
            .Imem2proc_data  (data),
            .Imem2proc_valid (valid),
            .Imem2proc_err   (err),
            .outstanding     (outs)
        );

        // Model: each accepted request is due at edge (accept edge + L - 1)
        // and is visible for that one cycle; flush/reset forget all pending ones.
        logic [31:0] mm [1024];
        exp_t        q [$];
        int          edge_n = 0;
        logic        ev;
        logic [31:0] ed;
        logic        ee;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
            end else begin
                edge_n++;
                while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
                if (flush) q.delete();
                if (req) begin
                    if (fetch_addr[31:2] < 30'd1024)
                        q.push_back('{data: mm[fetch_addr[11:2]], err: 1'b0, due: edge_n + L - 1});
                    else
                        q.push_back('{data: NOOP, err: 1'b1, due: edge_n + L - 1});
                end
                if (load_en && load_addr[31:2] < 30'd1024) mm[load_addr[11:2]] = load_data;
            end
        end

        always @(negedge clk) begin
            ev = (q.size() > 0) && (q[0].due == edge_n);
            ed = ev ? q[0].data : NOOP;
            ee = ev ? q[0].err : 1'b0;
            check($sformatf("L%0d valid", L), 32'(valid), 32'(ev));
            check($sformatf("L%0d data", L), data, ed);
            check($sformatf("L%0d err", L), 32'(err), 32'(ee));
            check($sformatf("L%0d outstanding", L), 32'(outs), 32'(q.size()));
        end

        always @(posedge rst) begin
            #1;
            check($sformatf("L%0d async rst valid", L), 32'(valid), 32'd0);
            check($sformatf("L%0d async rst data", L), data, NOOP);
            check($sformatf("L%0d async rst err", L), 32'(err), 32'd0);
            check($sformatf("L%0d async rst outstanding", L), 32'(outs), 32'd0);
        end
    end

    initial begin
        rst = 1'b0; req = 1'b0; fetch_addr = '0; flush = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #1 rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;

        // Preload every word so all fetches have defined contents.
        for (int i = 0; i < 1024; i++) begin
            load_en = 1'b1; load_addr = 32'(i * 4); load_data = 32'h5000_0000 + 32'(i);
            cyc();
        end
        for (int i = 0; i < 8; i++) begin
            load_addr = 32'(i * 4); load_data = 32'hA000_0000 + 32'(i);
            cyc();
        end
        load_en = 1'b0;

        // Back-to-back stream, pinned on the LATENCY=2 instance.
        for (int k = 0; k < 8; k++) begin
            req = 1'b1; fetch_addr = 32'(k * 4);
            cyc();
            if (k >= 1) check("L2 stream word", g_lat[1].data, 32'hA000_0000 + 32'(k - 1));
        end
        req = 1'b0;
        cyc();
        check("L2 stream last word", g_lat[1].data, 32'hA000_0007);
        check("L2 stream last valid", 32'(g_lat[1].valid), 32'd1);

        // Range and alignment, pinned on the LATENCY=1 instance.
        req = 1'b1; fetch_addr = 32'h0000_0FFE;
        cyc();
        check("L1 word 1023", g_lat[0].data, 32'h5000_03FF);
        fetch_addr = 32'h0000_1000;
        cyc();
        check("L1 oor data", g_lat[0].data, NOOP);
        check("L1 oor err", 32'(g_lat[0].err), 32'd1);
        check("L1 oor valid", 32'(g_lat[0].valid), 32'd1);
        req = 1'b0; load_en = 1'b1; load_addr = 32'h0000_1000; load_data = 32'hDEAD_BEEF;
        cyc();
        load_en = 1'b0; req = 1'b1; fetch_addr = 32'h0;
        cyc();
        check("L1 word 0 intact", g_lat[0].data, 32'hA000_0000);

        // Same-word load and fetch.
        req = 1'b0; load_en = 1'b1; load_addr = 32'h14; load_data = 32'h1111_1111;
        cyc();
        req = 1'b1; fetch_addr = 32'h14; load_data = 32'h2222_2222;
        cyc();
        check("L1 conflict old", g_lat[0].data, 32'h1111_1111);
        load_en = 1'b0;
        cyc();
        check("L1 conflict new", g_lat[0].data, 32'h2222_2222);
        req = 1'b0;
        repeat (5) cyc();

        // Flush, pinned on the LATENCY=3 instance.
        req = 1'b1; fetch_addr = 32'h0;
        cyc();
        check("L3 outstanding a", 32'(g_lat[2].outs), 32'd1);
        fetch_addr = 32'h4;
        cyc();
        check("L3 outstanding b", 32'(g_lat[2].outs), 32'd2);
        fetch_addr = 32'h8;
        cyc();
        check("L3 outstanding c", 32'(g_lat[2].outs), 32'd3);
        fetch_addr = 32'h40; flush = 1'b1;
        cyc();
        check("L3 outstanding flush", 32'(g_lat[2].outs), 32'd1);
        check("L3 killed valid a", 32'(g_lat[2].valid), 32'd0);
        req = 1'b0; flush = 1'b0;
        cyc();
        check("L3 killed valid b", 32'(g_lat[2].valid), 32'd0);
        cyc();
        check("L3 target valid", 32'(g_lat[2].valid), 32'd1);
        check("L3 target data", g_lat[2].data, 32'h5000_0010);
        cyc();
        check("L3 drained outstanding", 32'(g_lat[2].outs), 32'd0);
        repeat (4) cyc();

        // Asynchronous reset with responses in flight, pinned on LATENCY=4.
        req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fetch_addr = 32'(k * 4);
            cyc();
        end
        req = 1'b0;
        check("L4 in flight", 32'(g_lat[3].outs), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("L4 rst outstanding", 32'(g_lat[3].outs), 32'd0);
        check("L4 rst valid", 32'(g_lat[3].valid), 32'd0);
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        req = 1'b1; fetch_addr = 32'h40;
        cyc();
        req = 1'b0;
        repeat (2) cyc();
        check("L4 before due", 32'(g_lat[3].valid), 32'd0);
        cyc();
        check("L4 after rst valid", 32'(g_lat[3].valid), 32'd1);
        check("L4 after rst data", g_lat[3].data, 32'h5000_0010);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch stage's requests. Accepts one word-aligned fetch request per cycle on the `proc2Imem_*` interface and returns the instruction word in order after a fixed, parameterised latency. Sits between the processor's fetch stage and the program storage. Also provides a preload write port for the testbench/loader, and a flush that discards in-flight responses on a taken branch.

## Interface

Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words stored. Must be a power of two, 16..65536.
- `LATENCY`, default 1: fetch response latency in cycles. Legal range 1..4.

Ports:
- `clk`  in  1  system clock. All state is updated on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `proc2Imem_req`  in  1  fetch request valid this cycle.
- `proc2Imem_addr`  in  32  fetch byte address. Bits [1:0] are ignored.
- `flush`  in  1  discard all responses in flight (driven from the taken-branch signal).
- `load_en`  in  1  preload write enable.
- `load_addr`  in  32  preload byte address. Bits [1:0] are ignored.
- `load_data`  in  32  preload word.
- `Imem2proc_data`  out  32  returned instruction word.
- `Imem2proc_valid`  out  1  `Imem2proc_data` is a live response.
- `Imem2proc_err`  out  1  the response came from an out-of-range address.
- `outstanding`  out  3  number of accepted requests not yet returned (0..LATENCY).

## Operation

- Word index is `addr[31:2]`. An address is in range iff the index is less than `DEPTH_WORDS`.
- Storage is a DEPTH_WORDS x 32 array. Reset does not clear its contents.
- A request is accepted in every cycle where `proc2Imem_req`=1. There is no backpressure.
- The array is read in the acceptance cycle. The result (data, valid, err) then enters a LATENCY-deep shift pipeline.
- Out-of-range request: data = `NOOP_INST` (32'h00000013), err=1, valid=1.
- Out-of-range load: the write is dropped silently.
- Cycles with no request inject a bubble: valid=0, data=`NOOP_INST`, err=0.
- Output rules:
  - When valid=0, `Imem2proc_data` is `NOOP_INST` and err is 0.
  - When valid=1, the outputs carry the stage-LATENCY contents.
- Load and fetch to the same word in the same cycle: the fetch returns the value held before the write (read-before-write). The write is visible to fetches accepted in the following cycle onward.
- Flush:
  - On a rising edge with `flush`=1, every pipeline stage holding a request accepted in an earlier cycle is invalidated.
  - A request presented in the same cycle as `flush` is accepted normally and is not killed. This is the branch-target fetch.
- `outstanding` counts valid entries in the pipeline, including those not yet at the output stage.
  - It increments on acceptance.
  - It decrements as a response leaves the output register.
  - Flush sets it to 1 if a request is accepted in that cycle, else to 0.

## Timing

- Reset (asynchronous, takes effect immediately without a clock edge):
  - All pipeline valids are cleared.
  - `Imem2proc_valid`=0, `Imem2proc_data`=`NOOP_INST`, `Imem2proc_err`=0, `outstanding`=0.
- Reset asserted mid-operation drops all in-flight responses. The first valid response after release is for a request accepted after release.
- Latency: a request accepted at edge E appears with valid=1 for exactly one cycle, starting at edge E+LATENCY-1. For LATENCY=1 the response is visible in the cycle after the request.
- Throughput is one response per cycle. Back-to-back requests produce back-to-back responses in request order.
- Flush at edge E:
  - Responses that would have appeared at edges E..E+LATENCY-2 are suppressed.
  - The same-cycle request returns at E+LATENCY-1.
  - With LATENCY=1, flush has no visible effect on the response from the flush cycle.
- `load_en` is sampled at the edge. There is no latency on the write port.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

- Reset: assert `rst` asynchronously mid-cycle -> outputs go immediately to valid=0, data=32'h00000013, err=0, outstanding=0, with no clock edge required.
- Preload and stream (LATENCY=2): load words 0..7 with 32'hA000_0000+i, then request byte addresses 0,4,...,28 back-to-back -> the valid responses A0000000..A0000007 appear in order starting 2 cycles after the first request, with no gaps.
- Range/alignment (DEPTH_WORDS=1024):
  - Fetch address 32'h0000_0FFE -> returns word 1023.
  - Fetch address 32'h0000_1000 -> data=32'h00000013, err=1, valid=1.
  - Load to 32'h0000_1000 -> does not corrupt word 0.
- Same-word conflict: word 5 holds 32'h1111_1111. In one cycle, load 32'h2222_2222 to it and fetch it -> returns 32'h1111_1111. A fetch in the next cycle returns 32'h2222_2222.
- Flush (LATENCY=3): requests to addresses 0,4,8, then flush together with a request to 0x40 -> the responses for 0,4,8 never appear. Only the response for word 16 appears, 3 cycles after the flush cycle. `outstanding` goes 1,2,3, then 1.
- Reset mid-stream (LATENCY=4): pulse `rst` with 3 responses in flight -> none of them appear. A new request after release returns normally with latency 4.
